int_issue_queue: RTL and testbench

//  Age-ordered, collapsing integer issue queue directly downstream of dispatch.

---
 rtl/int_issue_queue.sv | 204 ++++++++++++++++++++
 tb/tb_int_issue_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_issue_queue.sv
// Age-ordered, collapsing integer issue queue: two dispatch slots in, writeback
// wakeup of source operands, one oldest-ready uop issued per cycle.
module int_issue_queue #(
   parameter int DEPTH     = 8,
   parameter int PREG_W    = 6,
   parameter int PAYLOAD_W = 128
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,

   input  logic                         enq0_valid,
   output logic                         enq0_ready,
   input  logic [PREG_W-1:0]            enq0_prs1,
   input  logic [PREG_W-1:0]            enq0_prs2,
   input  logic                         enq0_src1_is_reg,
   input  logic                         enq0_src2_is_reg,
   input  logic                         enq0_src1_rdy,
   input  logic                         enq0_src2_rdy,
   input  logic [PAYLOAD_W-1:0]         enq0_payload,

   input  logic                         enq1_valid,
   output logic                         enq1_ready,
   input  logic [PREG_W-1:0]            enq1_prs1,
   input  logic [PREG_W-1:0]            enq1_prs2,
   input  logic                         enq1_src1_is_reg,
   input  logic                         enq1_src2_is_reg,
   input  logic                         enq1_src1_rdy,
   input  logic                         enq1_src2_rdy,
   input  logic [PAYLOAD_W-1:0]         enq1_payload,

   input  logic                         wb0_valid,
   input  logic [PREG_W-1:0]            wb0_prd,
   input  logic                         wb1_valid,
   input  logic [PREG_W-1:0]            wb1_prd,

   output logic                         iss_valid,
   input  logic                         iss_ready,
   output logic [PREG_W-1:0]            iss_prs1,
   output logic [PREG_W-1:0]            iss_prs2,
   output logic [PAYLOAD_W-1:0]         iss_payload,

   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] PAIR_MAX = CNT_W'(DEPTH - 2);

   typedef struct packed {
      logic [PREG_W-1:0]    prs1;
      logic [PREG_W-1:0]    prs2;
      logic                 rdy1;
      logic                 rdy2;
      logic [PAYLOAD_W-1:0] payload;
   } entry_t;

   logic [DEPTH-1:0]     valid_q, valid_d;
   entry_t               ent_q [DEPTH];
   entry_t               ent_d [DEPTH];
   entry_t               woken [DEPTH];
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     base;

   logic [PREG_W-1:0]    hold_prs1_q, hold_prs1_d;
   logic [PREG_W-1:0]    hold_prs2_q, hold_prs2_d;
   logic [PAYLOAD_W-1:0] hold_payload_q, hold_payload_d;

   entry_t               enq0_ent, enq1_ent;
   logic                 enq0_fire, enq1_fire, iss_fire;
   logic                 sel_found;
   logic [IDX_W-1:0]     sel_idx;

   function automatic logic wb_hit(input logic [PREG_W-1:0] prs,
                                   input logic v0, input logic [PREG_W-1:0] p0,
                                   input logic v1, input logic [PREG_W-1:0] p1);
      return (v0 && (p0 == prs)) || (v1 && (p1 == prs));
   endfunction

   // Ready terms look only at registered count, keeping iss_ready off this path.
   assign enq0_ready = !flush && (cnt_q < FULL_CNT);
   assign enq1_ready = !flush && (cnt_q <= PAIR_MAX) && enq0_valid;
   assign enq0_fire  = enq0_valid && enq0_ready;
   assign enq1_fire  = enq1_valid && enq1_ready;
   assign count      = cnt_q;

   always_comb begin
      enq0_ent = '{prs1:    enq0_prs1,
                   prs2:    enq0_prs2,
                   rdy1:    !enq0_src1_is_reg || enq0_src1_rdy ||
                            wb_hit(enq0_prs1, wb0_valid, wb0_prd, wb1_valid, wb1_prd),
                   rdy2:    !enq0_src2_is_reg || enq0_src2_rdy ||
                            wb_hit(enq0_prs2, wb0_valid, wb0_prd, wb1_valid, wb1_prd),
                   payload: enq0_payload};
      enq1_ent = '{prs1:    enq1_prs1,
                   prs2:    enq1_prs2,
                   rdy1:    !enq1_src1_is_reg || enq1_src1_rdy ||
                            wb_hit(enq1_prs1, wb0_valid, wb0_prd, wb1_valid, wb1_prd),
                   rdy2:    !enq1_src2_is_reg || enq1_src2_rdy ||
                            wb_hit(enq1_prs2, wb0_valid, wb0_prd, wb1_valid, wb1_prd),
                   payload: enq1_payload};
   end

   // Sticky wakeup; only affects select from the next cycle on.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         woken[i] = ent_q[i];
         if (valid_q[i] && wb_hit(ent_q[i].prs1, wb0_valid, wb0_prd, wb1_valid, wb1_prd))
            woken[i].rdy1 = 1'b1;
         if (valid_q[i] && wb_hit(ent_q[i].prs2, wb0_valid, wb0_prd, wb1_valid, wb1_prd))
            woken[i].rdy2 = 1'b1;
      end
   end

   // Lowest index is oldest, so the first ready hit is the oldest-ready uop.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!sel_found && valid_q[i] && ent_q[i].rdy1 && ent_q[i].rdy2) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   assign iss_valid = sel_found && !flush;
   assign iss_fire  = iss_valid && iss_ready;

   always_comb begin
      hold_prs1_d    = hold_prs1_q;
      hold_prs2_d    = hold_prs2_q;
      hold_payload_d = hold_payload_q;
      if (sel_found) begin
         hold_prs1_d    = ent_q[sel_idx].prs1;
         hold_prs2_d    = ent_q[sel_idx].prs2;
         hold_payload_d = ent_q[sel_idx].payload;
      end
   end

   assign iss_prs1    = hold_prs1_d;
   assign iss_prs2    = hold_prs2_d;
   assign iss_payload = hold_payload_d;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      valid_d = valid_q;
      ent_d   = woken;
      base    = cnt_q - CNT_W'(iss_fire);
      if (iss_fire) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (i >= int'(sel_idx)) begin
               valid_d[i] = valid_q[i+1];
               ent_d[i]   = woken[i+1];
            end
         end
         valid_d[DEPTH-1] = 1'b0;
      end
      // New uops pack behind the survivors; slot 1 only fires when slot 0 does.
      for (int i = 0; i < DEPTH; i++) begin
         if (enq0_fire && (CNT_W'(i) == base)) begin
            valid_d[i] = 1'b1;
            ent_d[i]   = enq0_ent;
         end
         if (enq1_fire && (CNT_W'(i) == base + CNT_W'(1))) begin
            valid_d[i] = 1'b1;
            ent_d[i]   = enq1_ent;
         end
      end
      cnt_d = cnt_q - CNT_W'(iss_fire) + CNT_W'(enq0_fire) + CNT_W'(enq1_fire);
      if (flush) begin
         valid_d = '0;
         cnt_d   = '0;
      end
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: entry data is not reset; a cleared valid bit makes its contents invisible.
   always_ff @(posedge clock) begin
      ent_q          <= ent_d;
      hold_prs1_q    <= hold_prs1_d;
      hold_prs2_q    <= hold_prs2_d;
      hold_payload_q <= hold_payload_d;
   end

   a_enq1_needs_enq0: assert property (@(posedge clock) disable iff (reset)
      !(enq1_valid && !enq0_valid));
   a_count_bound: assert property (@(posedge clock) disable iff (reset)
      cnt_q <= FULL_CNT);
   a_valid_packed: assert property (@(posedge clock) disable iff (reset)
      (valid_q & (valid_q + DEPTH'(1))) == '0);

endmodule

// File: tb/tb_int_issue_queue.sv
// Scoreboard bench for int_issue_queue: expected issue payloads are queued as
// stimulus is driven and popped whenever the queue issues.
module tb_int_issue_queue;

   localparam int DEPTH     = 8;
   localparam int PREG_W    = 6;
   localparam int PAYLOAD_W = 128;

   typedef logic [PAYLOAD_W-1:0] pl_t;
   typedef struct packed {
      logic [PREG_W-1:0] prs1;
      logic [PREG_W-1:0] prs2;
      logic              is1;
      logic              is2;
      logic              r1;
      logic              r2;
      pl_t               pl;
   } uop_t;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              flush = 1'b0;
   logic              enq0_valid, enq0_ready, enq1_valid, enq1_ready;
   logic [PREG_W-1:0] enq0_prs1, enq0_prs2, enq1_prs1, enq1_prs2;
   logic              enq0_src1_is_reg, enq0_src2_is_reg, enq0_src1_rdy, enq0_src2_rdy;
   logic              enq1_src1_is_reg, enq1_src2_is_reg, enq1_src1_rdy, enq1_src2_rdy;
   pl_t               enq0_payload, enq1_payload;
   logic              wb0_valid, wb1_valid;
   logic [PREG_W-1:0] wb0_prd, wb1_prd;
   logic              iss_valid;
   logic              iss_ready = 1'b1;
   logic [PREG_W-1:0] iss_prs1, iss_prs2;
   pl_t               iss_payload;
   logic [3:0]        count;

   int  n_checks = 0;
   int  n_fail   = 0;
   pl_t exp_q[$];

   always #5 clock = ~clock;

   int_issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .enq0_valid(enq0_valid), .enq0_ready(enq0_ready),
      .enq0_prs1(enq0_prs1), .enq0_prs2(enq0_prs2),
      .enq0_src1_is_reg(enq0_src1_is_reg), .enq0_src2_is_reg(enq0_src2_is_reg),
      .enq0_src1_rdy(enq0_src1_rdy), .enq0_src2_rdy(enq0_src2_rdy),
      .enq0_payload(enq0_payload),
      .enq1_valid(enq1_valid), .enq1_ready(enq1_ready),
      .enq1_prs1(enq1_prs1), .enq1_prs2(enq1_prs2),
      .enq1_src1_is_reg(enq1_src1_is_reg), .enq1_src2_is_reg(enq1_src2_is_reg),
      .enq1_src1_rdy(enq1_src1_rdy), .enq1_src2_rdy(enq1_src2_rdy),
      .enq1_payload(enq1_payload),
      .wb0_valid(wb0_valid), .wb0_prd(wb0_prd),
      .wb1_valid(wb1_valid), .wb1_prd(wb1_prd),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_prs1(iss_prs1), .iss_prs2(iss_prs2), .iss_payload(iss_payload),
      .count(count)
   );

   task automatic check(input string tag, input logic [PAYLOAD_W-1:0] got,
                        input logic [PAYLOAD_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic pl_t plv(input int tag);
      logic [7:0] b;
      b = 8'(tag);
      return {16{b}};
   endfunction

   function automatic uop_t mk(input int prs1, input logic rdy, input int tag);
      uop_t u;
      u.prs1 = PREG_W'(prs1);
      u.prs2 = '0;
      u.is1  = 1'b1;
      u.is2  = 1'b0;
      u.r1   = rdy;
      u.r2   = 1'b0;
      u.pl   = plv(tag);
      return u;
   endfunction

   task automatic drive0(input uop_t u);
      enq0_valid = 1'b1;  enq0_prs1 = u.prs1;  enq0_prs2 = u.prs2;
      enq0_src1_is_reg = u.is1;  enq0_src2_is_reg = u.is2;
      enq0_src1_rdy = u.r1;  enq0_src2_rdy = u.r2;  enq0_payload = u.pl;
   endtask

   task automatic drive1(input uop_t u);
      enq1_valid = 1'b1;  enq1_prs1 = u.prs1;  enq1_prs2 = u.prs2;
      enq1_src1_is_reg = u.is1;  enq1_src2_is_reg = u.is2;
      enq1_src1_rdy = u.r1;  enq1_src2_rdy = u.r2;  enq1_payload = u.pl;
   endtask

   task automatic idle();
      enq0_valid = 1'b0;  enq1_valid = 1'b0;
      wb0_valid  = 1'b0;  wb1_valid  = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // An issue fires at the next rising edge whenever valid&ready hold mid-cycle.
   always @(negedge clock) begin
      if (!reset && iss_valid && iss_ready) begin
         if (exp_q.size() == 0) check("iss_unexpected", 1'b1, 1'b0);
         else check("iss_payload", iss_payload, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      uop_t u;
      drive0(mk(0, 0, 0));  drive1(mk(0, 0, 0));  idle();
      wb0_prd = '0;  wb1_prd = '0;

      // 1: reset state, then a ready pair issues in slot order
      repeat (2) cyc();
      check("rst_count", count, 0);
      check("rst_iss_valid", iss_valid, 0);
      check("rst_enq0_ready", enq0_ready, 1);
      reset = 1'b0;
      drive0(mk(5, 1, 'h10));  drive1(mk(6, 1, 'h11));
      #1 check("t1_enq1_ready", enq1_ready, 1);
      exp_q.push_back(plv('h10));  exp_q.push_back(plv('h11));
      cyc();  idle();
      check("t1_count2", count, 2);
      check("t1_iss_valid", iss_valid, 1);
      check("t1_prs_a", iss_prs1, 5);
      cyc();
      check("t1_count1", count, 1);
      check("t1_prs_b", iss_prs1, 6);
      cyc();
      check("t1_count0", count, 0);
      check("t1_empty", iss_valid, 0);

      // 2: younger ready uop bypasses older blocked one; wakeup takes one cycle
      drive0(mk(7, 0, 'h20));  drive1(mk(8, 1, 'h21));
      exp_q.push_back(plv('h21));
      cyc();  idle();
      check("t2_prs_b", iss_prs1, 8);
      cyc();
      check("t2_count1", count, 1);
      check("t2_blocked", iss_valid, 0);
      wb0_valid = 1'b1;  wb0_prd = 7;
      #1 check("t2_no_bypass", iss_valid, 0);
      exp_q.push_back(plv('h20));
      cyc();  idle();
      check("t2_woken", iss_valid, 1);
      check("t2_prs_a", iss_prs1, 7);
      cyc();
      check("t2_count0", count, 0);

      // 3: wakeup in the write cycle makes the entry ready on arrival
      u = mk(0, 0, 'h30);
      u.is1 = 1'b0;  u.is2 = 1'b1;  u.prs2 = 9;  u.r2 = 1'b0;
      drive0(u);
      wb1_valid = 1'b1;  wb1_prd = 9;
      exp_q.push_back(plv('h30));
      cyc();  idle();
      check("t3_iss_valid", iss_valid, 1);
      check("t3_prs2", iss_prs2, 9);
      check("t3_count1", count, 1);
      cyc();
      check("t3_count0", count, 0);

      // 4: fill with blocked uops, ready thresholds at 7 and 8
      for (int k = 0; k < 3; k++) begin
         drive0(mk(16 + 2*k, 0, 'h40 + 2*k));
         drive1(mk(17 + 2*k, 0, 'h41 + 2*k));
         #1 check("t4_fill_rdy0", enq0_ready, 1);
         check("t4_fill_rdy1", enq1_ready, 1);
         cyc();  idle();
         check("t4_fill_count", count, 2*k + 2);
      end
      drive0(mk(22, 0, 'h46));
      cyc();  idle();
      check("t4_count7", count, 7);
      drive0(mk(23, 0, 'h47));  drive1(mk(60, 0, 'h5F));
      #1 check("t4_c7_rdy0", enq0_ready, 1);
      check("t4_c7_rdy1", enq1_ready, 0);
      cyc();  idle();
      check("t4_count8", count, 8);
      drive0(mk(61, 0, 'h4F));  drive1(mk(62, 0, 'h4E));
      wb0_valid = 1'b1;  wb0_prd = 19;
      #1 check("t4_full_rdy0", enq0_ready, 0);
      check("t4_full_rdy1", enq1_ready, 0);
      exp_q.push_back(plv('h43));
      cyc();
      wb0_valid = 1'b0;
      #1 check("t4_full_count", count, 8);
      check("t4_full_iss", iss_valid, 1);
      check("t4_full_iss_prs", iss_prs1, 19);
      check("t4_full_rdy0_iss", enq0_ready, 0);
      cyc();
      check("t4_count_after", count, 7);
      check("t4_rdy0_after", enq0_ready, 1);
      idle();

      // 5: collapse around a middle issue with a same-cycle pair enqueue
      wb0_valid = 1'b1;  wb0_prd = 16;  wb1_valid = 1'b1;  wb1_prd = 17;
      exp_q.push_back(plv('h40));  exp_q.push_back(plv('h41));
      cyc();  idle();
      cyc();
      check("t5_count6", count, 6);
      cyc();
      check("t5_count5", count, 5);
      wb0_valid = 1'b1;  wb0_prd = 21;
      cyc();  idle();
      drive0(mk(30, 1, 'h50));  drive1(mk(31, 0, 'h51));
      exp_q.push_back(plv('h45));
      #1 check("t5_mid_count", count, 5);
      check("t5_mid_iss", iss_valid, 1);
      check("t5_mid_prs", iss_prs1, 21);
      check("t5_mid_rdy1", enq1_ready, 1);
      exp_q.push_back(plv('h50));
      cyc();  idle();
      check("t5_net_count", count, 6);
      cyc();
      check("t5_after_50", count, 5);
      wb0_valid = 1'b1;  wb0_prd = 20;  wb1_valid = 1'b1;  wb1_prd = 31;
      exp_q.push_back(plv('h44));  exp_q.push_back(plv('h51));
      cyc();  idle();
      cyc();
      cyc();
      check("t5_count3", count, 3);

      // 6: flush with a ready entry and a pending enqueue
      drive0(mk(40, 0, 'h52));
      cyc();  idle();
      check("t6_count4", count, 4);
      iss_ready = 1'b0;
      wb0_valid = 1'b1;  wb0_prd = 18;
      cyc();  idle();
      check("t6_pre_iss", iss_valid, 1);
      check("t6_pre_prs", iss_prs1, 18);
      flush = 1'b1;
      drive0(mk(41, 1, 'h53));
      #1 check("t6_flush_iss", iss_valid, 0);
      check("t6_flush_rdy0", enq0_ready, 0);
      cyc();  idle();
      check("t6_flush_count", count, 0);
      cyc();
      check("t6_post_count", count, 0);
      check("t6_post_iss", iss_valid, 0);

      // async reset mid-stream clears without waiting for an edge
      drive0(mk(50, 1, 'h60));  drive1(mk(51, 0, 'h61));
      cyc();  idle();
      check("t6_pre_rst_count", count, 2);
      #2 reset = 1'b1;
      #1 check("t6_rst_count", count, 0);
      check("t6_rst_iss", iss_valid, 0);
      check("t6_rst_rdy0", enq0_ready, 1);
      cyc();
      reset = 1'b0;
      iss_ready = 1'b1;
      drive0(mk(52, 1, 'h70));
      exp_q.push_back(plv('h70));
      cyc();  idle();
      check("t6_reuse_count1", count, 1);
      cyc();
      check("t6_reuse_count0", count, 0);
      cyc();
      check("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
